tb_csr_bank: RTL and testbench

TB_CSR_BANK -- requirements
Module: tb_csr_bank

---
 rtl/tb_csr_bank.sv | 139 +++++++++++++
 tb/tb_tb_csr_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_csr_bank.sv
// tb_csr_bank: CSR bank with ID, SCRATCH, CTRL, sticky STATUS and a 64-bit cycle counter.
// Define TB_CSR_RAM_EN to add the 16-word byte-writable RAM at offsets 0x40-0x7C.
module tb_csr_bank #(
    parameter logic [31:0] ID_VALUE      = 32'h7A67_0001,
    // Counter value loaded by reset; zero in normal use.
    parameter logic [63:0] CYCLE_RST_VAL = 64'h0
) (
    input  logic        sysclk,
    input  logic        sys_rstn,
    input  logic        ce,
    input  logic        we,
    input  logic [31:2] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  bytesel,
    input  logic [15:0] evt,
    output logic [31:0] rd,
    output logic [7:0]  ctrl_out,
    output logic [31:0] async_status
);

    localparam logic [5:0] W_ID      = 6'h00;
    localparam logic [5:0] W_SCRATCH = 6'h01;
    localparam logic [5:0] W_CTRL    = 6'h02;
    localparam logic [5:0] W_STATUS  = 6'h03;
    localparam logic [5:0] W_CYC_LO  = 6'h04;
    localparam logic [5:0] W_CYC_HI  = 6'h05;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    logic [5:0]  word;
    logic        wr_en;
    logic        rd_en;
    logic        unused_addr_hi;

    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] status_q, status_d;
    logic [15:0] status_clr;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] async_q, async_d;
    logic [31:0] rdata;

    // Upper address bits alias onto the same 64-word window.
    assign word           = addr[7:2];
    assign unused_addr_hi = ^addr[31:8];
    assign wr_en          = ce & we;
    assign rd_en          = ce & ~we;

`ifdef TB_CSR_RAM_EN
    logic [31:0] ram_q [16];
    logic [31:0] ram_d [16];
    logic        ram_sel;

    assign ram_sel = (word[5:4] == 2'b01);

    always_comb begin
        ram_d = ram_q;
        if (wr_en && ram_sel) begin
            ram_d[word[3:0]] = byte_merge(ram_q[word[3:0]], wd, bytesel);
        end
    end

    // No reset on the array; an edge seen while reset is low must not write.
    always_ff @(posedge sysclk) begin
        if (sys_rstn) ram_q <= ram_d;
    end
`endif

    always_comb begin
        rdata = 32'h0;
        case (word)
            W_ID:      rdata = ID_VALUE;
            W_SCRATCH: rdata = scratch_q;
            W_CTRL:    rdata = {24'h0, ctrl_q};
            W_STATUS:  rdata = {16'h0, status_q};
            W_CYC_LO:  rdata = cycle_q[31:0];
            W_CYC_HI:  rdata = snap_q;
            default:   rdata = 32'h0;
        endcase
`ifdef TB_CSR_RAM_EN
        if (ram_sel) rdata = ram_q[word[3:0]];
`endif
    end

    always_comb begin
        scratch_d  = scratch_q;
        ctrl_d     = ctrl_q;
        status_clr = 16'h0;
        if (wr_en) begin
            if (word == W_SCRATCH) scratch_d = byte_merge(scratch_q, wd, bytesel);
            if (word == W_CTRL && bytesel[0]) ctrl_d = wd[7:0];
            if (word == W_STATUS) begin
                status_clr = wd[15:0] & {{8{bytesel[1]}}, {8{bytesel[0]}}};
            end
        end
        // Applying the event after the clear lets a coincident set win.
        status_d = (status_q & ~status_clr) | evt;
        cycle_d  = cycle_q + 64'd1;
        snap_d   = (rd_en && word == W_CYC_LO) ? cycle_q[63:32] : snap_q;
        rd_d     = rd_en ? rdata : rd_q;
        async_d  = {status_q, 8'h00, ctrl_q[6:0], |status_q};
    end

    always_ff @(posedge sysclk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            scratch_q <= 32'h0;
            ctrl_q    <= 8'h0;
            status_q  <= 16'h0;
            cycle_q   <= CYCLE_RST_VAL;
            snap_q    <= 32'h0;
            rd_q      <= 32'h0;
            async_q   <= 32'h0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            cycle_q   <= cycle_d;
            snap_q    <= snap_d;
            rd_q      <= rd_d;
            async_q   <= async_d;
        end
    end

    assign rd           = rd_q;
    assign ctrl_out     = ctrl_q;
    assign async_status = async_q;

endmodule

// File: tb/tb_tb_csr_bank.sv
// Bench for tb_csr_bank: directed steps plus randomized accesses checked against a register-map model.
`timescale 1ns/1ps
module tb_tb_csr_bank;

    localparam logic [31:0] ID_EXP    = 32'h7A67_0001;
    localparam logic [63:0] CNT2_INIT = 64'h0000_0000_FFFF_FFF0;

    logic        sysclk   = 1'b0;
    logic        sys_rstn = 1'b1;
    logic        ce       = 1'b0;
    logic        ce2      = 1'b0;
    logic        we       = 1'b0;
    logic [31:2] addr     = '0;
    logic [31:0] wd       = '0;
    logic [3:0]  bytesel  = '0;
    logic [15:0] evt      = '0;
    logic [31:0] rd, async_status, rd2, unused_async2;
    logic [7:0]  ctrl_out, unused_ctrl2;

    always #5 sysclk = ~sysclk;

    tb_csr_bank dut (
        .sysclk(sysclk), .sys_rstn(sys_rstn), .ce(ce), .we(we), .addr(addr),
        .wd(wd), .bytesel(bytesel), .evt(evt), .rd(rd), .ctrl_out(ctrl_out),
        .async_status(async_status)
    );

    // Second instance with a preloaded counter to reach the 32-bit carry quickly.
    tb_csr_bank #(.CYCLE_RST_VAL(CNT2_INIT)) dut2 (
        .sysclk(sysclk), .sys_rstn(sys_rstn), .ce(ce2), .we(1'b0), .addr(addr),
        .wd(wd), .bytesel(bytesel), .evt(evt), .rd(rd2), .ctrl_out(unused_ctrl2),
        .async_status(unused_async2)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] m_scratch, m_snap, m_rd, m_async;
    logic [31:0] m_ram [16];
    logic [7:0]  m_ctrl;
    logic [15:0] m_status;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = 0; m_snap = 0; m_rd = 0; m_async = 0;
        m_ctrl = 0; m_status = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] ba);
        int off;
        off = int'(ba % 256);
        if (off == 'h00) return ID_EXP;
        if (off == 'h04) return m_scratch;
        if (off == 'h08) return {24'h0, m_ctrl};
        if (off == 'h0C) return {16'h0, m_status};
        if (off == 'h10) return m_cnt[31:0];
        if (off == 'h14) return m_snap;
`ifdef TB_CSR_RAM_EN
        if (off >= 'h40 && off <= 'h7C) return m_ram[(off - 'h40) / 4];
`endif
        return 32'h0;
    endfunction

    // Applies one clock edge's worth of architectural effects to the model.
    task automatic model_edge(input bit c, input bit w, input logic [31:0] ba,
                              input logic [31:0] d, input logic [3:0] be, input logic [15:0] e);
        int          off;
        logic [31:0] mask;
        logic [15:0] old_st, clr;
        logic [7:0]  old_ctrl;
        if (!sys_rstn) return;
        off      = int'(ba % 256);
        mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        old_st   = m_status;
        old_ctrl = m_ctrl;
        clr      = 16'h0;
        if (c && !w) begin
            m_rd = model_read(ba);
            if (off == 'h10) m_snap = m_cnt[63:32];
        end
        if (c && w) begin
            if (off == 'h04) m_scratch = (m_scratch & ~mask) | (d & mask);
            if (off == 'h08 && be[0]) m_ctrl = d[7:0];
            if (off == 'h0C) clr = d[15:0] & mask[15:0];
            if (off >= 'h40 && off <= 'h7C)
                m_ram[(off - 'h40) / 4] = (m_ram[(off - 'h40) / 4] & ~mask) | (d & mask);
        end
        m_status = (old_st & ~clr) | e;
        m_async  = {old_st, 8'h00, old_ctrl[6:0], |old_st};
        m_cnt    = m_cnt + 64'd1;
    endtask

    task automatic cyc(input bit c, input bit w, input logic [31:0] ba,
                       input logic [31:0] d, input logic [3:0] be, input logic [15:0] e);
        ce = c; we = w; addr = ba[31:2]; wd = d; bytesel = be; evt = e;
        @(posedge sysclk);
        model_edge(c, w, ba, d, be, e);
        @(negedge sysclk);
        ce = 1'b0; we = 1'b0; evt = 16'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd"}, rd, m_rd);
        check({tag, ".ctrl_out"}, {24'h0, ctrl_out}, {24'h0, m_ctrl});
        check({tag, ".async_status"}, async_status, m_async);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int offs [14] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h3C,
                          'h40, 'h48, 'h64, 'h7C, 'h80, 'hFC};
        logic [31:0] exp_ram;
        logic [31:0] ba;

        // Asynchronous reset with no clock edge yet.
        #1 sys_rstn = 1'b0;
        #1;
        model_reset();
        check("reset.rd", rd, 32'h0);
        check("reset.ctrl_out", {24'h0, ctrl_out}, 32'h0);
        check("reset.async_status", async_status, 32'h0);
        @(negedge sysclk);
        @(negedge sysclk);
        sys_rstn = 1'b1;

        // First edge after release sees the counter at zero.
        cyc(1, 0, 32'h10, 0, 0, 0);
        check("cnt_start", rd, 32'h0);
        check_all("cnt_start");

        // Snapshot of the high word is taken at the LO read, before the carry.
        while (m_cnt < 14) cyc(0, 0, 32'h0, 0, 0, 0);
        ce2 = 1'b1;
        cyc(0, 0, 32'h10, 0, 0, 0);
        ce2 = 1'b0;
        check("snap.lo", rd2, 32'hFFFF_FFFE);
        cyc(0, 0, 32'h0, 0, 0, 0);
        ce2 = 1'b1;
        cyc(0, 0, 32'h14, 0, 0, 0);
        ce2 = 1'b0;
        check("snap.hi", rd2, 32'h0);

        cyc(1, 0, 32'h00, 0, 0, 0);
        check("id", rd, ID_EXP);
        cyc(1, 0, 32'h04, 0, 0, 0);
        check("scratch.reset", rd, 32'h0);
        check_all("scratch.reset");

        for (int i = 0; i < 16; i++) cyc(1, 1, 32'h40 + 4 * i, $urandom, 4'hF, 0);

        cyc(1, 1, 32'h04, 32'hAABB_CCDD, 4'hF, 0);
        check_all("write.keeps_rd");
        cyc(1, 1, 32'h04, 32'h1122_3344, 4'b0101, 0);
        cyc(1, 0, 32'h04, 0, 0, 0);
        check("scratch.bytes", rd, 32'hAA22_CC44);
        check_all("scratch.bytes");

        cyc(0, 0, 32'h0, 0, 0, 16'h0008);
        cyc(1, 0, 32'h0C, 0, 0, 0);
        check("status.set", rd, 32'h0000_0008);
        check("async.bit0", {31'h0, async_status[0]}, 32'h1);
        cyc(1, 1, 32'h0C, 32'h8, 4'b0001, 16'h0008);
        cyc(1, 0, 32'h0C, 0, 0, 0);
        check("status.set_wins", rd, 32'h0000_0008);
        cyc(1, 1, 32'h0C, 32'h8, 4'b0001, 0);
        cyc(1, 0, 32'h0C, 0, 0, 0);
        check("status.clear", rd, 32'h0);
        check_all("status.clear");

`ifdef TB_CSR_RAM_EN
        exp_ram = 32'hDEAD_BEEF;
`else
        exp_ram = 32'h0;
`endif
        cyc(1, 1, 32'h48, 32'hDEAD_BEEF, 4'hF, 0);
        cyc(1, 0, 32'h48, 0, 0, 0);
        check("ram.read", rd, exp_ram);
        cyc(1, 0, 32'h148, 0, 0, 0);
        check("ram.alias", rd, exp_ram);

        cyc(1, 1, 32'h08, 32'hFFFF_FFA5, 4'hF, 0);
        cyc(1, 0, 32'h08, 0, 0, 0);
        check("ctrl.read", rd, 32'h0000_00A5);
        check("ctrl.out", {24'h0, ctrl_out}, 32'h0000_00A5);

        cyc(1, 1, 32'h00, 32'h1234_5678, 4'hF, 0);
        cyc(1, 0, 32'h00, 0, 0, 0);
        check("id.ro", rd, ID_EXP);
        cyc(1, 1, 32'h3C, 32'h1234_5678, 4'hF, 0);
        cyc(1, 0, 32'h3C, 0, 0, 0);
        check("unmapped", rd, 32'h0);
        cyc(1, 1, 32'h10, 32'h0, 4'hF, 0);
        cyc(1, 0, 32'h10, 0, 0, 0);
        check_all("cycle.ro");

        for (int n = 0; n < 300; n++) begin
            ba = ($urandom & 32'hFFFF_FF00) | 32'(offs[$urandom_range(0, 13)]);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ba, $urandom,
                4'($urandom), ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0);
            check_all("random");
        end

        // Reset in the cycle after a CTRL write, while a SCRATCH write is pending.
        cyc(0, 0, 32'h0, 0, 0, 16'h8000);
        cyc(1, 1, 32'h08, 32'h0000_005A, 4'b0001, 0);
        check("ctrl.pre_reset", {24'h0, ctrl_out}, 32'h0000_005A);
        check_all("pre_reset");
        ce = 1'b1; we = 1'b1; addr = 30'h1; wd = 32'h1234_5678; bytesel = 4'hF;
        #2 sys_rstn = 1'b0;
        #1;
        model_reset();
        check("async_rst.ctrl_out", {24'h0, ctrl_out}, 32'h0);
        check("async_rst.async_status", async_status, 32'h0);
        check("async_rst.rd", rd, 32'h0);
        @(negedge sysclk);
        ce = 1'b0; we = 1'b0;
        @(negedge sysclk);
        sys_rstn = 1'b1;
        cyc(1, 0, 32'h10, 0, 0, 0);
        check("cnt_restart", rd, 32'h0);
        cyc(1, 0, 32'h04, 0, 0, 0);
        check("abort.scratch", rd, 32'h0);
        cyc(1, 0, 32'h48, 0, 0, 0);
        check_all("ram.no_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
